// File: rtl/btb_predictor.sv
// btb_predictor
//   Direct-mapped fetch-stage branch target buffer with 2-bit saturating
//   direction counters and return-address-stack hooks.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   fetch_pc          PC being fetched; lookup is combinational
//   ras_top/ras_valid return-address-stack top and non-empty flag
//   pred_next_pc      predicted next fetch PC
//   pred_taken        prediction redirects away from fetch_pc+4
//   pred_hit          valid entry with matching tag
//   pred_type         00 branch, 01 jump, 10 call, 11 return
//   ras_push_req      hit on a call; the RAS pushes fetch_pc+4
//   ras_pop_req       hit on a return while the RAS is non-empty
//   upd_*             training write from execute, applied on the clock edge
module btb_predictor #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = XLEN - INDEX_BITS - 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic [XLEN-1:0] ras_top,
  input  logic            ras_valid,
  output logic [XLEN-1:0] pred_next_pc,
  output logic            pred_taken,
  output logic            pred_hit,
  output logic [1:0]      pred_type,
  output logic            ras_push_req,
  output logic            ras_pop_req,
  input  logic            upd_en,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken,
  input  logic [1:0]      upd_type
);

  localparam int         ENTRIES     = 1 << INDEX_BITS;
  localparam logic [1:0] TYPE_BRANCH = 2'b00;
  localparam logic [1:0] TYPE_JUMP   = 2'b01;
  localparam logic [1:0] TYPE_CALL   = 2'b10;

  logic [ENTRIES-1:0]  valid_q;
  logic [1:0]          ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];
  logic [1:0]          type_q   [ENTRIES];

  // Instructions are word aligned; the two low PC bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{fetch_pc[1:0], upd_pc[1:0]};

  // ---------------------------------------------------------------- lookup
  logic [INDEX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0]   fetch_tag;
  logic [XLEN-1:0]       fetch_seq_pc;
  logic                  fetch_hit;

  assign fetch_idx    = fetch_pc[INDEX_BITS+1:2];
  assign fetch_tag    = fetch_pc[XLEN-1:INDEX_BITS+2];
  assign fetch_seq_pc = fetch_pc + XLEN'(4);
  // Gating with reset makes the outputs fall to the miss case the moment
  // reset rises, without waiting for the table clear to propagate.
  assign fetch_hit    = !reset && valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  always_comb begin
    pred_next_pc = fetch_seq_pc;
    pred_taken   = 1'b0;
    pred_hit     = fetch_hit;
    pred_type    = 2'b00;
    ras_push_req = 1'b0;
    ras_pop_req  = 1'b0;
    if (fetch_hit) begin
      pred_type = type_q[fetch_idx];
      case (type_q[fetch_idx])
        TYPE_BRANCH: begin
          if (ctr_q[fetch_idx][1]) begin
            pred_taken   = 1'b1;
            pred_next_pc = target_q[fetch_idx];
          end
        end
        TYPE_JUMP: begin
          pred_taken   = 1'b1;
          pred_next_pc = target_q[fetch_idx];
        end
        TYPE_CALL: begin
          pred_taken   = 1'b1;
          pred_next_pc = target_q[fetch_idx];
          ras_push_req = 1'b1;
        end
        default: begin
          // Return: the stored target is ignored, the RAS supplies it.
          if (ras_valid) begin
            pred_taken   = 1'b1;
            pred_next_pc = ras_top;
            ras_pop_req  = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- update
  logic [INDEX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0]   upd_tag;
  logic                  upd_tag_hit;
  logic                  upd_write;
  logic [1:0]            upd_ctr_cur;
  logic [1:0]            upd_ctr_next;

  assign upd_idx     = upd_pc[INDEX_BITS+1:2];
  assign upd_tag     = upd_pc[XLEN-1:INDEX_BITS+2];
  assign upd_tag_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // Not-taken results never allocate an entry.
  assign upd_write   = upd_en && (upd_tag_hit || upd_taken);
  assign upd_ctr_cur = ctr_q[upd_idx];

  always_comb begin
    upd_ctr_next = upd_ctr_cur;
    if (upd_tag_hit) begin
      if (upd_type == TYPE_BRANCH) begin
        if (upd_taken) begin
          if (upd_ctr_cur != 2'b11) upd_ctr_next = upd_ctr_cur + 2'd1;
        end else begin
          if (upd_ctr_cur != 2'b00) upd_ctr_next = upd_ctr_cur - 2'd1;
        end
      end else begin
        upd_ctr_next = 2'b11;
      end
    end else begin
      // Fresh allocation: branches start weakly taken, others strongly.
      upd_ctr_next = (upd_type == TYPE_BRANCH) ? 2'b10 : 2'b11;
    end
  end

  // Tag, target and type hold their contents across reset; only valid and
  // the counters are cleared. Keeping everything in one process also drops
  // any update that lands on an edge while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
    end else if (upd_write) begin
      valid_q[upd_idx]  <= 1'b1;
      ctr_q[upd_idx]    <= upd_ctr_next;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target;
      type_q[upd_idx]   <= upd_type;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// tb_btb_predictor
//   Directed scenarios plus a randomized run, all checked against a small
//   behavioural table model of the predictor kept inside this module.
module tb_btb_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc, ras_top;
  logic        ras_valid;
  logic [31:0] pred_next_pc;
  logic        pred_taken, pred_hit;
  logic [1:0]  pred_type;
  logic        ras_push_req, ras_pop_req;
  logic        upd_en;
  logic [31:0] upd_pc, upd_target;
  logic        upd_taken;
  logic [1:0]  upd_type;

  int vectors     = 0;
  int miscompares = 0;

  btb_predictor #(.XLEN(32), .INDEX_BITS(6)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc), .ras_top(ras_top),
    .ras_valid(ras_valid), .pred_next_pc(pred_next_pc), .pred_taken(pred_taken),
    .pred_hit(pred_hit), .pred_type(pred_type), .ras_push_req(ras_push_req),
    .ras_pop_req(ras_pop_req), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .upd_type(upd_type)
  );

  always #5 clk = ~clk;

  // {next_pc, taken, hit, type, push, pop}
  logic [37:0] got, exp;
  assign got = {pred_next_pc, pred_taken, pred_hit, pred_type, ras_push_req, ras_pop_req};

  // ------------------------------------------------------- reference model
  bit          m_valid  [64];
  int unsigned m_tag    [64];
  logic [31:0] m_target [64];
  logic [1:0]  m_type   [64];
  int          m_ctr    [64];

  function automatic logic [37:0] model_pred(input logic [31:0] pc, input logic [31:0] rtop,
                                             input logic rv, input logic rst);
    int          i   = int'((pc / 4) % 64);
    int unsigned t   = pc / 256;
    logic [31:0] seq = pc + 32'd4;
    if (rst || !m_valid[i] || m_tag[i] != t) return {seq, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
    case (m_type[i])
      2'b00:   return (m_ctr[i] >= 2) ? {m_target[i], 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}
                                      : {seq, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0};
      2'b01:   return {m_target[i], 1'b1, 1'b1, 2'b01, 1'b0, 1'b0};
      2'b10:   return {m_target[i], 1'b1, 1'b1, 2'b10, 1'b1, 1'b0};
      default: return rv ? {rtop, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1}
                         : {seq, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic model_train(input logic [31:0] pc, input logic [31:0] target,
                             input logic taken, input logic [1:0] ty);
    int          i = int'((pc / 4) % 64);
    int unsigned t = pc / 256;
    if (m_valid[i] && m_tag[i] == t) begin
      if (ty == 2'b00) m_ctr[i] = taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                        : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      else             m_ctr[i] = 3;
      m_target[i] = target;
      m_type[i]   = ty;
    end else if (taken) begin
      m_valid[i]  = 1'b1;
      m_tag[i]    = t;
      m_target[i] = target;
      m_type[i]   = ty;
      m_ctr[i]    = (ty == 2'b00) ? 2 : 3;
    end
  endtask

  // Advance one clock; inputs change only at the falling edge.
  task automatic tick();
    @(posedge clk);
    if (upd_en && !reset) model_train(upd_pc, upd_target, upd_taken, upd_type);
    @(negedge clk);
  endtask

  task automatic do_update(input logic [31:0] pc, input logic [31:0] target,
                           input logic taken, input logic [1:0] ty);
    upd_en = 1'b1; upd_pc = pc; upd_target = target; upd_taken = taken; upd_type = ty;
    tick();
    upd_en = 1'b0;
  endtask

  // ------------------------------------------------------------- scenarios
  task automatic test_reset();
    reset = 1'b1; model_reset();
    fetch_pc = 32'h100; ras_top = 32'h0; ras_valid = 1'b0;
    upd_en = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0; upd_type = 2'b00;
    #1;
    vectors++;
    if (got !== {32'h104, 6'b000000}) begin
      miscompares++; $display("FAIL reset_asserted: got %h required %h", got, {32'h104, 6'b000000});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp = model_pred(fetch_pc, ras_top, ras_valid, reset);
    vectors++;
    if (got !== exp || exp !== {32'h104, 6'b000000}) begin
      miscompares++; $display("FAIL reset_released: got %h required %h", got, exp);
    end
  endtask

  task automatic test_branch_counter();
    logic       steps_taken [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] unused_ty;
    unused_ty = 2'b00;
    fetch_pc = 32'h100;
    do_update(32'h100, 32'h80, 1'b1, unused_ty);
    #1;
    vectors++;
    if (got !== {32'h80, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL branch_alloc: got %h required %h", got, {32'h80, 6'b110000});
    end
    for (int s = 0; s < 6; s++) begin
      do_update(32'h100, 32'h80, steps_taken[s], 2'b00);
      #1;
      exp = model_pred(fetch_pc, ras_top, ras_valid, reset);
      vectors++;
      if (got !== exp) begin
        miscompares++; $display("FAIL branch_ctr_step%0d: got %h required %h", s, got, exp);
      end
      if (s == 1) begin
        vectors++;
        if (got !== {32'h104, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0}) begin
          miscompares++; $display("FAIL branch_ctr_floor: got %h required %h", got, {32'h104, 6'b010000});
        end
      end
      if (s == 5) begin
        // saturated at 11 after three taken, one not-taken leaves it taken
        vectors++;
        if (got !== {32'h80, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}) begin
          miscompares++; $display("FAIL branch_ctr_sat: got %h required %h", got, {32'h80, 6'b110000});
        end
      end
    end
  endtask

  task automatic test_call_return();
    do_update(32'h200, 32'h400, 1'b1, 2'b10);
    fetch_pc = 32'h200;
    #1;
    vectors++;
    if (got !== {32'h400, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL call_push: got %h required %h", got, {32'h400, 6'b111010});
    end
    do_update(32'h410, 32'hDEAD0000, 1'b1, 2'b11);
    fetch_pc = 32'h410; ras_top = 32'h204; ras_valid = 1'b1;
    #1;
    vectors++;
    if (got !== {32'h204, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1}) begin
      miscompares++; $display("FAIL return_pop: got %h required %h", got, {32'h204, 6'b111101});
    end
    ras_valid = 1'b0;
    #1;
    vectors++;
    if (got !== {32'h414, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL return_empty_ras: got %h required %h", got, {32'h414, 6'b011100});
    end
  endtask

  task automatic test_alias();
    do_update(32'h100, 32'h80, 1'b1, 2'b00);
    do_update(32'h1100, 32'h900, 1'b1, 2'b00);
    fetch_pc = 32'h100;
    #1;
    vectors++;
    if (got !== {32'h104, 6'b000000}) begin
      miscompares++; $display("FAIL alias_evicted: got %h required %h", got, {32'h104, 6'b000000});
    end
    fetch_pc = 32'h1100;
    #1;
    vectors++;
    if (got !== {32'h900, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL alias_new: got %h required %h", got, {32'h900, 6'b110000});
    end
    do_update(32'h1C, 32'h500, 1'b0, 2'b00);
    fetch_pc = 32'h1C;
    #1;
    vectors++;
    if (got !== {32'h20, 6'b000000}) begin
      miscompares++; $display("FAIL nt_no_alloc: got %h required %h", got, {32'h20, 6'b000000});
    end
  endtask

  task automatic test_same_cycle();
    fetch_pc = 32'h300;
    upd_en = 1'b1; upd_pc = 32'h300; upd_target = 32'h600; upd_taken = 1'b1; upd_type = 2'b01;
    #1;
    vectors++;
    if (got !== {32'h304, 6'b000000}) begin
      miscompares++; $display("FAIL same_cycle_old: got %h required %h", got, {32'h304, 6'b000000});
    end
    tick();
    upd_en = 1'b0;
    #1;
    vectors++;
    if (got !== {32'h600, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0}) begin
      miscompares++; $display("FAIL same_cycle_next: got %h required %h", got, {32'h600, 6'b110100});
    end
  endtask

  task automatic test_async_reset();
    fetch_pc = 32'h300;
    #3;
    reset = 1'b1; model_reset();
    #1;
    vectors++;
    if (got !== {32'h304, 6'b000000}) begin
      miscompares++; $display("FAIL async_reset_now: got %h required %h", got, {32'h304, 6'b000000});
    end
    // training pulse overlapping reset must be dropped
    upd_en = 1'b1; upd_pc = 32'h1C; upd_target = 32'h700; upd_taken = 1'b1; upd_type = 2'b01;
    tick();
    upd_en = 1'b0;
    #2;
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      fetch_pc = (k == 0) ? 32'h300 : 32'h1C;
      #1;
      exp = model_pred(fetch_pc, ras_top, ras_valid, reset);
      vectors++;
      if (got !== exp || pred_hit !== 1'b0) begin
        miscompares++; $display("FAIL async_reset_after%0d: got %h required %h", k, got, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap();
    fetch_pc = 32'hFFFFFFFC;
    #1;
    vectors++;
    if (got !== {32'h0, 6'b000000}) begin
      miscompares++; $display("FAIL pc_wrap: got %h required %h", got, {32'h0, 6'b000000});
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int unsigned tags [4] = '{32'h0, 32'h1, 32'h11, 32'hFFFFFF};
    for (int n = 0; n < 600; n++) begin
      upd_en     = ($urandom_range(0, 1) == 1);
      upd_pc     = (tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, 7) << 2);
      upd_target = $urandom & 32'hFFFFFFFC;
      upd_taken  = ($urandom_range(0, 3) != 0);
      upd_type   = 2'($urandom_range(0, 3));
      fetch_pc   = ($urandom_range(0, 3) == 0) ? upd_pc
                 : ((tags[$urandom_range(0, 3)] << 8) | ($urandom_range(0, 7) << 2));
      ras_top    = $urandom;
      ras_valid  = ($urandom_range(0, 1) == 1);
      #1;
      exp = model_pred(fetch_pc, ras_top, ras_valid, reset);
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random_%0d pc=%h: got %h required %h", n, fetch_pc, got, exp);
      end
      tick();
    end
    upd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_branch_counter();
    test_call_return();
    test_alias();
    test_same_cycle();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Fetch-stage branch target buffer with 2-bit saturating direction counters.
- Each cycle it takes the fetch PC and produces the predicted next PC.
- For return-type entries it consumes the return-address-stack top and valid signals; for call-type entries it raises a push request to the return-address stack.
- The table is trained by resolved control-flow results from the execute stage.

Parameters:
- XLEN, 32, address/data width.
- INDEX_BITS, 6, log2 of entry count (64 entries, direct-mapped).
- TAG_BITS, XLEN-INDEX_BITS-2, tag width taken from pc[XLEN-1:INDEX_BITS+2].

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- fetch_pc  in  XLEN  PC being fetched this cycle.
- ras_top  in  XLEN  current return-address-stack top.
- ras_valid  in  1  return-address-stack non-empty.
- pred_next_pc  out  XLEN  predicted next fetch PC.
- pred_taken  out  1  prediction redirects away from fetch_pc+4.
- pred_hit  out  1  tag match on a valid entry.
- pred_type  out  2  type of the hit entry: 00 branch, 01 jump, 10 call, 11 return.
- ras_push_req  out  1  hit entry is a call; the RAS pushes fetch_pc+4.
- ras_pop_req  out  1  hit entry is a return and ras_valid=1.
- upd_en  in  1  training write from execute.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_target  in  XLEN  resolved target.
- upd_taken  in  1  resolved direction.
- upd_type  in  2  resolved type (same encoding as pred_type).

Behaviour:
- Storage per entry: valid, tag, target[XLEN-1:0], type[1:0], ctr[1:0].
- Index is pc[INDEX_BITS+1:2].

Lookup (combinational, same cycle as fetch_pc):
- hit = valid[idx] & (tag[idx]==fetch_pc tag field).
- Miss: pred_taken=0, pred_next_pc=fetch_pc+4 (modulo 2^XLEN), push/pop requests 0, pred_type=00.
- Hit, branch: pred_taken=ctr[1]; next PC = target if taken, else fetch_pc+4.
- Hit, jump or call: pred_taken=1, next PC = stored target. Call also asserts ras_push_req.
- Hit, return with ras_valid=1: pred_taken=1, next PC = ras_top, ras_pop_req=1.
- Hit, return with ras_valid=0: pred_taken=0, next PC = fetch_pc+4, no pop.

Update (registered, on rising clk when upd_en=1):
- Tag hit, branch:
  - ctr saturating +1 if upd_taken, -1 otherwise (bounded 00..11).
  - target and type overwritten.
- Tag hit, non-branch: ctr forced to 11; target and type overwritten.
- Tag miss, upd_taken=1: allocate (overwrite) the entry.
  - valid=1, tag, target, type written.
  - ctr=10 for branch, 11 otherwise.
- Tag miss, upd_taken=0: no change. Not-taken branches are never allocated.
- Returns train the type only; their stored target is still written, but prediction ignores it.

Simultaneous events and reset:
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents. There is no bypass; the new value is visible next cycle.
- Reset (asynchronous, any time, including mid-update): all valid=0, all ctr=01.
  - Target, tag and type need not be reset.
  - While reset is asserted, outputs follow the miss case: pred_next_pc=fetch_pc+4, pred_taken=0, pred_hit=0, push/pop requests 0.
  - An upd_en pulse coinciding with reset is discarded.
- Aliasing: entries differing only in tag evict each other. There is no associativity.
- No internal pipeline state other than the table. Latency from training to visible prediction is 1 cycle.

Test Plan:
- Reset, then fetch_pc=0x100 -> pred_hit=0, pred_taken=0, pred_next_pc=0x104.
- upd branch pc=0x100 target=0x80 taken, then fetch 0x100 -> hit, ctr=10, taken, next=0x80. Then two not-taken updates -> ctr=00, next=0x104. Then three taken updates -> ctr saturates at 11.
- upd call pc=0x200 target=0x400, fetch 0x200 -> next=0x400, ras_push_req=1, pred_type=10. upd return pc=0x410, fetch 0x410 with ras_top=0x204, ras_valid=1 -> next=0x204, ras_pop_req=1. Same with ras_valid=0 -> next=0x414, pop 0.
- Alias: train 0x100 taken to 0x80, then train 0x1100 (same index) taken to 0x900 -> fetch 0x100 misses (next 0x104), fetch 0x1100 -> 0x900. Not-taken update at an empty index -> still miss.
- Same-cycle upd_en and fetch to 0x300 -> old (miss) result that cycle, hit the next cycle. Assert reset mid-sequence asynchronously (between edges) -> all lookups miss immediately and after release.
- fetch_pc=0xFFFFFFFC miss -> pred_next_pc=0x00000000 (wrap).
